// File: rtl/usb_tx_packetizer.sv
// Packet framer feeding the app-to-FTDI FIFO: header, payload, trailer, checksum.
// Each word is registered onto fifo_data/fifo_wren one cycle after it is produced.
module usb_tx_packetizer #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [15:0] STREAM_ID = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] fifo_data,
    output logic        fifo_wren,
    input  logic        fifo_almost_full,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SEQ_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        TRAILER,
        CHECKSUM
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [31:0]      csum, csum_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [SEQ_W-1:0] seq, seq_n;
    logic [15:0]      pkt_count_n;
    logic [31:0]      word_n;
    logic             wr_n;
    logic             wr_ok;
    logic             accept;

    assign wr_ok  = !fifo_almost_full;
    assign accept = in_valid && in_ready;

    // Next-state, word selection and counter updates
    always_comb begin
        state_n     = state;
        count_n     = count;
        csum_n      = csum;
        timer_n     = timer;
        seq_n       = seq;
        pkt_count_n = pkt_count;
        word_n      = '0;
        wr_n        = 1'b0;
        in_ready    = 1'b0;

        case (state)
            IDLE: begin
                // Header only goes out with a pending word, so packets are never empty
                if (enable && in_valid && wr_ok) begin
                    wr_n    = 1'b1;
                    word_n  = {8'hA5, seq, STREAM_ID};
                    count_n = '0;
                    csum_n  = '0;
                    timer_n = '0;
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                in_ready = wr_ok;
                if (accept) begin
                    wr_n    = 1'b1;
                    word_n  = in_data;
                    count_n = count + CNT_W'(1);
                    csum_n  = csum + in_data;
                    timer_n = '0;
                    if (in_last || (count_n == CNT_W'(MAX_WORDS))) begin
                        state_n = TRAILER;
                    end
                end else begin
                    timer_n = timer + TMR_W'(1);
                    if (timer_n == TMR_W'(TIMEOUT)) begin
                        state_n = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (wr_ok) begin
                    wr_n    = 1'b1;
                    word_n  = {8'h5A, seq, count};
                    state_n = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (wr_ok) begin
                    wr_n        = 1'b1;
                    word_n      = csum;
                    seq_n       = seq + SEQ_W'(1);
                    pkt_count_n = pkt_count + 16'd1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            csum      <= '0;
            timer     <= '0;
            seq       <= '0;
            pkt_count <= '0;
            fifo_data <= '0;
            fifo_wren <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            csum      <= csum_n;
            timer     <= timer_n;
            seq       <= seq_n;
            pkt_count <= pkt_count_n;
            fifo_wren <= wr_n;
            busy      <= (state_n != IDLE);
            if (wr_n) begin
                fifo_data <= word_n;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Directed bench for usb_tx_packetizer (MAX_WORDS=4, TIMEOUT=16).
// Captures every FIFO write and compares against hand values and a tiny framing model.
module tb_usb_tx_packetizer;

    localparam int unsigned MAX_WORDS = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] fifo_data;
    logic        fifo_wren;
    logic        fifo_almost_full;
    logic        busy;
    logic [15:0] pkt_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] got_q[$];
    int          got_t[$];
    logic [31:0] exp_q[$];
    logic [15:0] m_cnt;
    logic [31:0] m_sum;

    usb_tx_packetizer #(
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT  (TIMEOUT),
        .STREAM_ID(16'h0001)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .fifo_data       (fifo_data),
        .fifo_wren       (fifo_wren),
        .fifo_almost_full(fifo_almost_full),
        .busy            (busy),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (fifo_wren === 1'b1) begin
            got_q.push_back(fifo_data);
            got_t.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_q();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_q();
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit acc;
        int n;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (busy) chk("idle_wait", 32'(busy), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), got_at(i), exp_q[i]);
        end
        clear_q();
    endtask

    task automatic exp_hdr(input logic [7:0] s);
        exp_q.push_back({8'hA5, s, 16'h0001});
        m_cnt = '0;
        m_sum = '0;
    endtask

    task automatic exp_word(input logic [31:0] w);
        exp_q.push_back(w);
        m_cnt = m_cnt + 16'd1;
        m_sum = m_sum + w;
    endtask

    task automatic exp_close(input logic [7:0] s);
        exp_q.push_back({8'h5A, s, m_cnt});
        exp_q.push_back(m_sum);
    endtask

    initial begin
        int bad;
        int gap;
        reset            = 1'b1;
        enable           = 1'b0;
        in_data          = '0;
        in_valid         = 1'b0;
        in_last          = 1'b0;
        fifo_almost_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wren", 32'(fifo_wren), 32'd0);
        chk("rst_data", fifo_data, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        reset = 1'b0;

        // 4-word burst, in_last coincides with MAX_WORDS
        enable = 1'b1;
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        send(32'h44, 1'b1);
        wait_idle();
        exp_q = '{32'hA500_0001, 32'h11, 32'h22, 32'h33, 32'h44, 32'h5A00_0004, 32'h0000_00AA};
        compare_stream("t1");
        chk("t1_pkt", 32'(pkt_count), 32'd1);

        // Continuous stream split at MAX_WORDS
        do_reset();
        for (int i = 1; i <= 12; i++) send(32'(i), 1'b0);
        wait_idle();
        for (int p = 0; p < 3; p++) begin
            exp_hdr(8'(p));
            for (int w = 1; w <= 4; w++) exp_word(32'(p * 4 + w));
            exp_close(8'(p));
        end
        chk("t2_hdr1", got_at(7), 32'hA501_0001);
        chk("t2_trl2", got_at(19), 32'h5A02_0004);
        compare_stream("t2");
        chk("t2_pkt", 32'(pkt_count), 32'd3);

        // Timeout close: trailer registered one cycle after the TIMEOUT-th idle cycle
        send(32'h100, 1'b0);
        send(32'h200, 1'b0);
        send(32'h300, 1'b0);
        wait_idle();
        gap = (got_t.size() >= 5) ? (got_t[4] - got_t[3]) : -1;
        chk("t3_gap", 32'(gap), 32'(TIMEOUT + 1));
        exp_q = '{32'hA503_0001, 32'h100, 32'h200, 32'h300, 32'h5A03_0003, 32'h0000_0600};
        compare_stream("t3");

        // Almost-full stalls in PAYLOAD and TRAILER
        do_reset();
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        fifo_almost_full = 1'b1;
        in_data  = 32'h3;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1 || (i > 0 && fifo_wren !== 1'b0)) bad++;
            @(posedge clk);
            #1;
        end
        chk("t4_payload_stall", 32'(bad), 32'd0);
        fifo_almost_full = 1'b0;
        send(32'h3, 1'b0);
        send(32'h4, 1'b1);
        fifo_almost_full = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1 || (i > 0 && fifo_wren !== 1'b0)) bad++;
            @(posedge clk);
            #1;
        end
        chk("t4_trailer_stall", 32'(bad), 32'd0);
        fifo_almost_full = 1'b0;
        wait_idle();
        exp_q = '{32'hA500_0001, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5A00_0004, 32'h0000_000A};
        compare_stream("t4");

        // Checksum wrap, then seq wrap after 256 packets
        do_reset();
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0002, 1'b1);
        wait_idle();
        exp_q = '{32'hA500_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h5A00_0002, 32'h0000_0001};
        compare_stream("t5");
        for (int k = 1; k < 256; k++) send(32'(k), 1'b1);
        wait_idle();
        chk("t5_pkt256", 32'(pkt_count), 32'h100);
        clear_q();
        send(32'h55, 1'b1);
        wait_idle();
        chk("t5_seqwrap_hdr", got_at(0), 32'hA500_0001);
        chk("t5_seqwrap_trl", got_at(2), 32'h5A00_0001);

        // Asynchronous reset mid-packet
        clear_q();
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        in_data  = 32'hC;
        in_valid = 1'b1;
        reset = 1'b1;
        #1;
        chk("t6_wren", 32'(fifo_wren), 32'd0);
        chk("t6_data", fifo_data, 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pkt", 32'(pkt_count), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        clear_q();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_noenable_writes", 32'(got_q.size()), 32'd0);
        chk("t6_noenable_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        send(32'h77, 1'b1);
        wait_idle();
        exp_q = '{32'hA500_0001, 32'h77, 32'h5A00_0001, 32'h0000_0077};
        compare_stream("t6");
        chk("t6_pkt_after", 32'(pkt_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
